// File: rtl/grn_attractor_ctrl_if.sv
// rtl/grn_attractor_ctrl_if.sv - result record valid/ready channel of the GRN attractor controller
interface grn_attractor_ctrl_if #(
  parameter int N_NODES = 8,
  parameter int STEP_W  = 16
);
  logic               res_valid;
  logic               res_ready;
  logic [N_NODES-1:0] res_init;
  logic [N_NODES-1:0] res_state;
  logic [STEP_W-1:0]  res_steps;
  logic               res_timeout;

  modport master (
    output res_valid,
    output res_init,
    output res_state,
    output res_steps,
    output res_timeout,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_init,
    input  res_state,
    input  res_steps,
    input  res_timeout,
    output res_ready
  );
endinterface

// File: rtl/grn_attractor_ctrl.sv
// rtl/grn_attractor_ctrl.sv - sweeps initial GRN states and reports Floyd-detected attractors
// Optional step bound enabled by defining GRN_CTRL_TIMEOUT_EN.
module grn_attractor_ctrl #(
  parameter int N_NODES   = 8,
  parameter int STEP_W    = 16,
  parameter int MAX_STEPS = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [N_NODES-1:0] init_first_i,
  input  logic [N_NODES-1:0] init_last_i,
  input  logic [N_NODES-1:0] s0_state_i,
  input  logic [N_NODES-1:0] s1_state_i,
  output logic               reset_nos_o,
  output logic [N_NODES-1:0] init_state_o,
  output logic               start_s0_o,
  output logic               start_s1_o,
  output logic               busy_o,
  output logic               done_o,
  grn_attractor_ctrl_if.master res_if
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    REPORT = 3'd3,
    FIN    = 3'd4
  } state_e;

  localparam logic [STEP_W-1:0] MaxK = STEP_W'(MAX_STEPS);
  localparam logic [STEP_W-1:0] KSat = {STEP_W{1'b1}};

  state_e             state_q, state_d;
  logic [N_NODES-1:0] cur_q, cur_d;
  logic [N_NODES-1:0] last_q, last_d;
  logic [STEP_W-1:0]  k_q, k_d;
  logic [N_NODES-1:0] init_state_q, init_state_d;
  logic [N_NODES-1:0] res_init_q, res_init_d;
  logic [N_NODES-1:0] res_state_q, res_state_d;
  logic [STEP_W-1:0]  res_steps_q, res_steps_d;
  logic               res_tmo_q, res_tmo_d;
  logic               reset_nos_q;
  logic               busy_q;
  logic               done_q;
  logic               res_valid_q;
  logic               match;
  logic               tmo;
  logic               exit_run;
  logic               strobe;

  // s1 is at step 2m and s0 at step m only after an even, non-zero strobe count.
  assign match    = ~k_q[0] && (k_q >= STEP_W'(2)) && (s0_state_i == s1_state_i);
  assign exit_run = match || tmo;

`ifdef GRN_CTRL_TIMEOUT_EN
  assign tmo = (k_q == MaxK) && !match;
`else
  logic unused_max;
  assign tmo        = 1'b0;
  assign unused_max = ^MaxK;
`endif

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    last_d       = last_q;
    k_d          = k_q;
    init_state_d = init_state_q;
    res_init_d   = res_init_q;
    res_state_d  = res_state_q;
    res_steps_d  = res_steps_q;
    res_tmo_d    = res_tmo_q;
    strobe       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (init_first_i <= init_last_i) begin
            cur_d        = init_first_i;
            last_d       = init_last_i;
            init_state_d = init_first_i;
            state_d      = LOAD;
          end else begin
            state_d = FIN;
          end
        end
      end
      LOAD: begin
        k_d     = '0;
        state_d = RUN;
      end
      RUN: begin
        if (exit_run) begin
          res_init_d  = cur_q;
          res_state_d = s1_state_i;
          res_steps_d = k_q;
          res_tmo_d   = tmo;
          state_d     = REPORT;
        end else begin
          // Strobe gating needs this cycle's compare; the node outputs feeding it are flops.
          strobe = 1'b1;
          if (k_q != KSat) begin
            k_d = k_q + STEP_W'(1);
          end
        end
      end
      REPORT: begin
        if (res_if.res_ready) begin
          // Test against the last state before incrementing so an all-ones bound cannot wrap.
          if (cur_q == last_q) begin
            state_d = FIN;
          end else begin
            cur_d        = cur_q + N_NODES'(1);
            init_state_d = cur_q + N_NODES'(1);
            state_d      = LOAD;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      last_q       <= '0;
      k_q          <= '0;
      init_state_q <= '0;
      res_init_q   <= '0;
      res_state_q  <= '0;
      res_steps_q  <= '0;
      res_tmo_q    <= 1'b0;
      reset_nos_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      res_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_q       <= last_d;
      k_q          <= k_d;
      init_state_q <= init_state_d;
      res_init_q   <= res_init_d;
      res_state_q  <= res_state_d;
      res_steps_q  <= res_steps_d;
      res_tmo_q    <= res_tmo_d;
      reset_nos_q  <= (state_d == LOAD);
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == FIN);
      res_valid_q  <= (state_d == REPORT);
    end
  end

  assign reset_nos_o  = reset_nos_q;
  assign init_state_o = init_state_q;
  assign start_s0_o   = strobe;
  assign start_s1_o   = strobe;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

  assign res_if.res_valid   = res_valid_q;
  assign res_if.res_init    = res_init_q;
  assign res_if.res_state   = res_state_q;
  assign res_if.res_steps   = res_steps_q;
  assign res_if.res_timeout = res_tmo_q;

endmodule
